mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/lc3b_types.sv | 29 ++
 rtl/wb_lane_steer.sv | 46 ++++
 rtl/mem_access_unit.sv | 176 +++++++++++++++++
 tb/tb_mem_access_unit.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3b_types.sv
// Shared types for the LC-3b memory access unit: memory op codes, FSM states,
// and small helpers used when decoding an op.
package lc3b_types;

    typedef enum logic [2:0] {
        OP_NONE = 3'd0,
        OP_LD   = 3'd1,
        OP_ST   = 3'd2,
        OP_LDI  = 3'd3,
        OP_STI  = 3'd4,
        OP_TRAP = 3'd5
    } lc3b_mem_op;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC1 = 2'd1,
        S_ACC2 = 2'd2,
        S_DONE = 2'd3
    } mau_state_e;

    function automatic logic is_indirect(input lc3b_mem_op op);
        return (op == OP_LDI) || (op == OP_STI);
    endfunction

    function automatic logic [15:0] trap_addr(input logic [7:0] vect);
        return {7'b0000000, vect, 1'b0};
    endfunction

endpackage

// File: rtl/wb_lane_steer.sv
// Maps a 16-bit access at a byte offset onto a Wishbone line: lane enables,
// write-line placement and read-word extraction (bytes zero-extended).
module wb_lane_steer #(
    parameter  int LINE_WORDS = 8,
    localparam int OFS_W      = $clog2(2 * LINE_WORDS)
) (
    input  logic [OFS_W-1:0]         ofs,
    input  logic                     byte_acc,
    input  logic [15:0]              wdata,
    input  logic [16*LINE_WORDS-1:0] line_rd,
    output logic [2*LINE_WORDS-1:0]  sel,
    output logic [16*LINE_WORDS-1:0] line_wr,
    output logic [15:0]              rdata
);

    localparam int K_W = OFS_W - 1;

    logic [K_W-1:0]              k_s;
    logic [LINE_WORDS-1:0][15:0] rd_words_s;
    logic [LINE_WORDS-1:0][15:0] wr_words_s;
    logic [LINE_WORDS-1:0][1:0]  sel_pairs_s;
    logic [15:0]                 word_s;

    assign k_s        = ofs[OFS_W-1:1];
    assign rd_words_s = line_rd;
    assign word_s     = rd_words_s[k_s];

    // Little-endian lanes: odd byte offset is the upper half of word k.
    always_comb begin
        sel_pairs_s = '0;
        wr_words_s  = '0;
        if (byte_acc) begin
            sel_pairs_s[k_s] = ofs[0] ? 2'b10 : 2'b01;
            wr_words_s[k_s]  = {wdata[7:0], wdata[7:0]};
            rdata            = {8'h00, (ofs[0] ? word_s[15:8] : word_s[7:0])};
        end else begin
            sel_pairs_s[k_s] = 2'b11;
            wr_words_s[k_s]  = wdata;
            rdata            = word_s;
        end
    end

    assign sel     = sel_pairs_s;
    assign line_wr = wr_words_s;

endmodule

// File: rtl/mem_access_unit.sv
// LC-3b MEM-stage unit: runs LD/ST/LDI/STI/TRAP as one or two Wishbone
// accesses and holds the pipeline until the op completes.
module mem_access_unit
    import lc3b_types::*;
#(
    parameter  int LINE_WORDS = 8,
    localparam int OFS_W      = $clog2(2 * LINE_WORDS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     stall,
    input  logic                     req_valid,
    input  lc3b_mem_op               op,
    input  logic                     byte_mode,
    input  logic [15:0]              addr_in,
    input  logic [15:0]              wdata_in,
    input  logic [7:0]               trapvect8,
    output logic [16-OFS_W-1:0]      wb_adr,
    output logic                     wb_cyc,
    output logic                     wb_stb,
    output logic                     wb_we,
    output logic [2*LINE_WORDS-1:0]  wb_sel,
    output logic [16*LINE_WORDS-1:0] wb_dat_m,
    input  logic [16*LINE_WORDS-1:0] wb_dat_s,
    input  logic                     wb_ack,
    output logic [15:0]              rdata_out,
    output logic                     done,
    output logic                     request_stall
);

    mau_state_e  state_q, state_d;
    lc3b_mem_op  op_q, op_d;
    logic        byte_q, byte_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] addr_q, addr_d;
    logic        cyc_q, cyc_d;
    logic        we_q, we_d;
    logic        done_q, done_d;
    logic [15:0] rdata_q, rdata_d;

    logic                     final_acc_s;
    logic                     acc_byte_s;
    logic [2*LINE_WORDS-1:0]  sel_s;
    logic [16*LINE_WORDS-1:0] line_wr_s;
    logic [15:0]              rd_word_s;

    // Pointer and vector fetches are always whole words; byte_mode only shapes the last access.
    assign final_acc_s = (state_q == S_ACC2) || !(is_indirect(op_q) || (op_q == OP_TRAP));
    assign acc_byte_s  = byte_q && final_acc_s;

    wb_lane_steer #(.LINE_WORDS(LINE_WORDS)) u_steer (
        .ofs      (addr_q[OFS_W-1:0]),
        .byte_acc (acc_byte_s),
        .wdata    (wdata_q),
        .line_rd  (wb_dat_s),
        .sel      (sel_s),
        .line_wr  (line_wr_s),
        .rdata    (rd_word_s)
    );

    // Next-state and next-output logic for the access sequencer.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        byte_d  = byte_q;
        wdata_d = wdata_q;
        addr_d  = addr_q;
        cyc_d   = cyc_q;
        we_d    = we_q;
        done_d  = 1'b0;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid && (op != OP_NONE)) begin
                    state_d = S_ACC1;
                    op_d    = op;
                    byte_d  = byte_mode;
                    wdata_d = wdata_in;
                    addr_d  = (op == OP_TRAP) ? trap_addr(trapvect8) : addr_in;
                    cyc_d   = 1'b1;
                    we_d    = (op == OP_ST);
                end else begin
                    cyc_d = 1'b0;
                    we_d  = 1'b0;
                end
            end
            S_ACC1: begin
                if (wb_ack) begin
                    if (!we_q) begin
                        rdata_d = rd_word_s;
                    end else begin
                        rdata_d = rdata_q;
                    end
                    if (is_indirect(op_q)) begin
                        state_d = S_ACC2;
                        addr_d  = rd_word_s;
                        we_d    = (op_q == OP_STI);
                    end else begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        cyc_d   = 1'b0;
                        we_d    = 1'b0;
                    end
                end else begin
                    state_d = S_ACC1;
                end
            end
            S_ACC2: begin
                if (wb_ack) begin
                    if (!we_q) begin
                        rdata_d = rd_word_s;
                    end else begin
                        rdata_d = rdata_q;
                    end
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    cyc_d   = 1'b0;
                    we_d    = 1'b0;
                end else begin
                    state_d = S_ACC2;
                end
            end
            S_DONE: begin
                if (stall) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_IDLE;
                    done_d  = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                cyc_d   = 1'b0;
                we_d    = 1'b0;
            end
        endcase
    end

    // State and output registers; reset also aborts any bus cycle in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= OP_NONE;
            byte_q  <= 1'b0;
            wdata_q <= 16'h0000;
            addr_q  <= 16'h0000;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            rdata_q <= 16'h0000;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            byte_q  <= byte_d;
            wdata_q <= wdata_d;
            addr_q  <= addr_d;
            cyc_q   <= cyc_d;
            we_q    <= we_d;
            done_q  <= done_d;
            rdata_q <= rdata_d;
        end
    end

    assign wb_adr        = addr_q[15:OFS_W];
    assign wb_cyc        = cyc_q;
    assign wb_stb        = cyc_q;
    assign wb_we         = we_q;
    assign wb_sel        = cyc_q ? sel_s : '0;
    assign wb_dat_m      = (cyc_q && we_q) ? line_wr_s : '0;
    assign rdata_out     = rdata_q;
    assign done          = done_q;
    assign request_stall = (state_q == S_ACC1) || (state_q == S_ACC2) ||
                           ((state_q == S_IDLE) && req_valid && (op != OP_NONE));

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomised bench for mem_access_unit: a byte-addressed memory behind a
// wait-state Wishbone slave, checked against an op-level reference model.
module tb_mem_access_unit;
    import lc3b_types::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, stall, req_valid8, req_valid4, byte_mode;
    lc3b_mem_op  op;
    logic [15:0] addr_in, wdata_in;
    logic [7:0]  trapvect8;

    logic [11:0]  wb_adr8;
    logic         wb_cyc8, wb_stb8, wb_we8, wb_ack8, done8, rstall8;
    logic [15:0]  wb_sel8, rdata8;
    logic [127:0] wb_dat_m8, wb_dat_s8;

    logic [12:0]  wb_adr4;
    logic         wb_cyc4, wb_stb4, wb_we4, wb_ack4, done4, rstall4;
    logic [7:0]   wb_sel4;
    logic [15:0]  rdata4;
    logic [63:0]  wb_dat_m4, wb_dat_s4;

    logic [7:0] mem     [0:65535];
    logic [7:0] ref_mem [0:65535];

    int          n_cmp = 0;
    int          n_fail = 0;
    int          w_acc1 = 0;
    int          w_acc2 = 0;
    logic [15:0] last_rd = 16'h0000;

    mem_access_unit #(.LINE_WORDS(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .stall(stall), .req_valid(req_valid8), .op(op),
        .byte_mode(byte_mode), .addr_in(addr_in), .wdata_in(wdata_in), .trapvect8(trapvect8),
        .wb_adr(wb_adr8), .wb_cyc(wb_cyc8), .wb_stb(wb_stb8), .wb_we(wb_we8), .wb_sel(wb_sel8),
        .wb_dat_m(wb_dat_m8), .wb_dat_s(wb_dat_s8), .wb_ack(wb_ack8), .rdata_out(rdata8),
        .done(done8), .request_stall(rstall8)
    );

    mem_access_unit #(.LINE_WORDS(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .stall(stall), .req_valid(req_valid4), .op(op),
        .byte_mode(byte_mode), .addr_in(addr_in), .wdata_in(wdata_in), .trapvect8(trapvect8),
        .wb_adr(wb_adr4), .wb_cyc(wb_cyc4), .wb_stb(wb_stb4), .wb_we(wb_we4), .wb_sel(wb_sel4),
        .wb_dat_m(wb_dat_m4), .wb_dat_s(wb_dat_s4), .wb_ack(wb_ack4), .rdata_out(rdata4),
        .done(done4), .request_stall(rstall4)
    );

    // Wishbone slave for the 8-word unit: per-access wait states, writes commit on an accepted ack.
    initial begin : slave8
        int           cnt, idx;
        logic         ack_prev, rst_seen, p_we;
        logic [11:0]  p_adr;
        logic [15:0]  p_sel;
        logic [127:0] p_dat;
        cnt = 0; idx = 0; wb_ack8 = 1'b0; wb_dat_s8 = '0;
        p_we = 1'b0; p_adr = '0; p_sel = '0; p_dat = '0;
        forever begin
            @(posedge clk);
            rst_seen = rst_n;
            ack_prev = wb_ack8;
            #1;
            if (ack_prev) begin
                if (rst_seen && p_we) begin
                    for (int j = 0; j < 16; j++)
                        if (p_sel[j]) mem[16'({p_adr, 4'h0}) + 16'(j)] = p_dat[j*8 +: 8];
                end
                cnt = 0;
                idx++;
            end
            wb_ack8 = 1'b0;
            for (int j = 0; j < 16; j++) wb_dat_s8[j*8 +: 8] = mem[16'({wb_adr8, 4'h0}) + 16'(j)];
            if (wb_cyc8 && wb_stb8) begin
                if (cnt >= ((idx == 0) ? w_acc1 : w_acc2)) begin
                    wb_ack8 = 1'b1;
                    p_adr = wb_adr8; p_sel = wb_sel8; p_dat = wb_dat_m8; p_we = wb_we8;
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
                idx = 0;
            end
        end
    end

    // Zero-wait read-only slave for the 4-word unit.
    initial begin : slave4
        wb_ack4 = 1'b0; wb_dat_s4 = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int j = 0; j < 8; j++) wb_dat_s4[j*8 +: 8] = mem[16'({wb_adr4, 3'h0}) + 16'(j)];
            wb_ack4 = wb_cyc4 && wb_stb4;
        end
    end

    function automatic logic [15:0] rword(input logic [15:0] a);
        return {ref_mem[{a[15:1], 1'b1}], ref_mem[{a[15:1], 1'b0}]};
    endfunction

    function automatic logic [15:0] mword(input logic [15:0] a);
        return {mem[{a[15:1], 1'b1}], mem[{a[15:1], 1'b0}]};
    endfunction

    function automatic logic [15:0] exp_sel(input logic [15:0] a, input logic b);
        return b ? (16'd1 << a[3:0]) : (16'd3 << {a[3:1], 1'b0});
    endfunction

    function automatic logic [127:0] exp_line(input logic [15:0] a, input logic b, input logic [15:0] wd);
        logic [127:0] l;
        l = '0;
        l[int'(a[3:1])*16 +: 16] = b ? {wd[7:0], wd[7:0]} : wd;
        return l;
    endfunction

    task automatic poke(input logic [15:0] a, input logic [15:0] v);
        mem[a] = v[7:0]; mem[a + 16'd1] = v[15:8];
        ref_mem[a] = v[7:0]; ref_mem[a + 16'd1] = v[15:8];
    endtask

    task automatic run_op(input lc3b_mem_op o, input logic bm, input logic [15:0] a, input logic [15:0] wd,
                          input logic [7:0] tv, input int w1, input int w2, input bit hold);
        logic [15:0] a1, ptr, res, wtgt;
        logic        ind, fb, wr;
        int          exp_cyc, cyc;
        a1      = (o == OP_TRAP) ? {7'd0, tv, 1'b0} : a;
        ind     = (o == OP_LDI) || (o == OP_STI);
        fb      = bm && ((o == OP_LD) || (o == OP_ST));
        exp_cyc = 2 + w1 + (ind ? (w2 + 1) : 0);
        ptr     = rword(a);
        wr      = (o == OP_ST) || (o == OP_STI);
        wtgt    = (o == OP_STI) ? ptr : a;
        case (o)
            OP_LD:   res = bm ? {8'h00, ref_mem[a]} : rword(a);
            OP_TRAP: res = rword(a1);
            OP_LDI:  res = bm ? {8'h00, ref_mem[ptr]} : rword(ptr);
            OP_STI:  res = ptr;
            default: res = last_rd;
        endcase
        w_acc1 = w1; w_acc2 = w2;
        @(negedge clk);
        op = o; byte_mode = bm; addr_in = a; wdata_in = wd; trapvect8 = tv; req_valid8 = 1'b1; stall = 1'b0;
        #1;
        n_cmp++;
        if (rstall8 !== 1'b1) begin n_fail++; $display("FAIL req_stall_idle: got %b expected 1", rstall8); end
        cyc = 0;
        while (done8 !== 1'b1 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                req_valid8 = 1'b0; op = lc3b_mem_op'(3'($urandom_range(0, 5)));
                addr_in = 16'($urandom); wdata_in = 16'($urandom); trapvect8 = 8'($urandom); byte_mode = 1'($urandom);
                n_cmp++;
                if ({wb_cyc8, wb_stb8, wb_we8, wb_adr8, wb_sel8, rstall8} !== {2'b11, (o == OP_ST), a1[15:4], exp_sel(a1, fb), 1'b1}) begin
                    n_fail++;
                    $display("FAIL acc1_bus: got cyc%b stb%b we%b adr%h sel%h rs%b expected we%b adr%h sel%h",
                             wb_cyc8, wb_stb8, wb_we8, wb_adr8, wb_sel8, rstall8, (o == OP_ST), a1[15:4], exp_sel(a1, fb));
                end
                if (o == OP_ST) begin
                    n_cmp++;
                    if (wb_dat_m8 !== exp_line(a, bm, wd)) begin
                        n_fail++; $display("FAIL acc1_wdata: got %h expected %h", wb_dat_m8, exp_line(a, bm, wd));
                    end
                end
            end
            if (ind && cyc == w1 + 2) begin
                n_cmp++;
                if ({wb_cyc8, wb_we8, wb_adr8, wb_sel8} !== {1'b1, (o == OP_STI), ptr[15:4], exp_sel(ptr, bm)}) begin
                    n_fail++;
                    $display("FAIL acc2_bus: got cyc%b we%b adr%h sel%h expected we%b adr%h sel%h",
                             wb_cyc8, wb_we8, wb_adr8, wb_sel8, (o == OP_STI), ptr[15:4], exp_sel(ptr, bm));
                end
                if (o == OP_STI) begin
                    n_cmp++;
                    if (wb_dat_m8 !== exp_line(ptr, bm, wd)) begin
                        n_fail++; $display("FAIL acc2_wdata: got %h expected %h", wb_dat_m8, exp_line(ptr, bm, wd));
                    end
                end
            end
            stall = (done8 === 1'b1) ? hold : 1'($urandom);
        end
        if (done8 !== 1'b1) begin
            n_cmp++; n_fail++;
            $display("FAIL done_timeout: got no done after %0d cycles expected %0d", cyc, exp_cyc);
            stall = 1'b0;
            return;
        end
        if (wr) begin
            if (bm) begin
                ref_mem[wtgt] = wd[7:0];
            end else begin
                ref_mem[{wtgt[15:1], 1'b0}] = wd[7:0];
                ref_mem[{wtgt[15:1], 1'b1}] = wd[15:8];
            end
        end
        last_rd = res;
        n_cmp++;
        if (cyc != exp_cyc) begin n_fail++; $display("FAIL latency: got %0d expected %0d", cyc, exp_cyc); end
        n_cmp++;
        if (rdata8 !== res) begin n_fail++; $display("FAIL rdata: got %h expected %h", rdata8, res); end
        n_cmp++;
        if ({wb_cyc8, wb_stb8, wb_we8, wb_sel8, wb_dat_m8, rstall8} !== '0) begin
            n_fail++;
            $display("FAIL done_bus: got cyc%b stb%b we%b sel%h rs%b expected all zero", wb_cyc8, wb_stb8, wb_we8, wb_sel8, rstall8);
        end
        n_cmp++;
        if (mword(wtgt) !== rword(wtgt)) begin
            n_fail++; $display("FAIL mem_word: got %h expected %h at %h", mword(wtgt), rword(wtgt), wtgt);
        end
        if (hold) begin
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                n_cmp++;
                if ({done8, rdata8} !== {1'b1, res}) begin
                    n_fail++; $display("FAIL stall_hold: got done%b rdata%h expected done1 rdata%h", done8, rdata8, res);
                end
            end
            stall = 1'b0;
        end
        @(negedge clk);
        n_cmp++;
        if ({done8, wb_cyc8} !== 2'b00) begin
            n_fail++; $display("FAIL done_exit: got done%b cyc%b expected 00", done8, wb_cyc8);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; stall = 1'b0; req_valid8 = 1'b0; req_valid4 = 1'b0; op = OP_NONE;
        byte_mode = 1'b0; addr_in = 16'h0000; wdata_in = 16'h0000; trapvect8 = 8'h00;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({wb_cyc8, wb_stb8, wb_we8, wb_sel8, done8, rstall8, rdata8, wb_cyc4, done4, rdata4} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got cyc%b stb%b we%b sel%h done%b rs%b rd%h cyc4%b done4%b rd4%h expected all zero",
                     wb_cyc8, wb_stb8, wb_we8, wb_sel8, done8, rstall8, rdata8, wb_cyc4, done4, rdata4);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_idle_none();
        @(negedge clk);
        req_valid8 = 1'b1; op = OP_NONE;
        #1;
        n_cmp++;
        if (rstall8 !== 1'b0) begin n_fail++; $display("FAIL none_stall: got %b expected 0", rstall8); end
        @(negedge clk);
        n_cmp++;
        if ({wb_cyc8, done8} !== 2'b00) begin n_fail++; $display("FAIL none_idle: got cyc%b done%b expected 00", wb_cyc8, done8); end
        req_valid8 = 1'b0;
    endtask

    task automatic test_directed();
        poke(16'h1236, 16'hBEEF);
        run_op(OP_LD, 1'b0, 16'h1236, 16'h0000, 8'h00, 0, 0, 1'b0);
        n_cmp++;
        if (rdata8 !== 16'hBEEF) begin n_fail++; $display("FAIL ld_beef: got %h expected beef", rdata8); end
        run_op(OP_ST, 1'b1, 16'h2005, 16'h00A5, 8'h00, 0, 0, 1'b0);
        n_cmp++;
        if (mem[16'h2005] !== 8'hA5) begin n_fail++; $display("FAIL st_byte: got %h expected a5", mem[16'h2005]); end
        poke(16'h3000, 16'h4002);
        poke(16'h4002, 16'h1234);
        run_op(OP_LDI, 1'b0, 16'h3000, 16'h0000, 8'h00, 2, 2, 1'b0);
        n_cmp++;
        if (rdata8 !== 16'h1234) begin n_fail++; $display("FAIL ldi_1234: got %h expected 1234", rdata8); end
        run_op(OP_TRAP, 1'b0, 16'($urandom), 16'h0000, 8'h25, 1, 0, 1'b0);
        run_op(OP_LD, 1'b1, 16'($urandom), 16'h0000, 8'h00, 0, 0, 1'b1);
    endtask

    task automatic test_reset_mid();
        logic [15:0] ptr;
        poke(16'h5000, 16'h6006);
        ptr = 16'h6006;
        w_acc1 = 0; w_acc2 = 0;
        @(negedge clk);
        op = OP_STI; byte_mode = 1'b0; addr_in = 16'h5000; wdata_in = 16'hC3C3; req_valid8 = 1'b1; stall = 1'b0;
        @(negedge clk);
        req_valid8 = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({wb_cyc8, wb_we8, wb_adr8} !== {2'b11, ptr[15:4]}) begin
            n_fail++; $display("FAIL sti_acc2: got cyc%b we%b adr%h expected 11 %h", wb_cyc8, wb_we8, wb_adr8, ptr[15:4]);
        end
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({wb_cyc8, wb_stb8, wb_we8, wb_sel8, wb_dat_m8, done8, rstall8, rdata8} !== '0) begin
            n_fail++; $display("FAIL reset_mid: got cyc%b stb%b we%b done%b rs%b rd%h expected all zero",
                               wb_cyc8, wb_stb8, wb_we8, done8, rstall8, rdata8);
        end
        n_cmp++;
        if (mword(ptr) !== rword(ptr)) begin n_fail++; $display("FAIL reset_nowrite: got %h expected %h", mword(ptr), rword(ptr)); end
        rst_n = 1'b1;
        last_rd = 16'h0000;
    endtask

    task automatic test_random();
        lc3b_mem_op ops [5] = '{OP_LD, OP_ST, OP_LDI, OP_STI, OP_TRAP};
        for (int i = 0; i < 40; i++) begin
            run_op(ops[$urandom_range(0, 4)], 1'($urandom), 16'($urandom), 16'($urandom), 8'($urandom),
                   $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
        end
    endtask

    task automatic test_lw4();
        poke(16'h1236, 16'hBEEF);
        @(negedge clk);
        op = OP_LD; byte_mode = 1'b0; addr_in = 16'h1236; req_valid4 = 1'b1; stall = 1'b0;
        @(negedge clk);
        req_valid4 = 1'b0;
        n_cmp++;
        if ({wb_cyc4, wb_we4, wb_adr4, wb_sel4} !== {2'b10, 13'h0246, 8'hC0}) begin
            n_fail++; $display("FAIL lw4_ld_bus: got cyc%b we%b adr%h sel%h expected 1 0 0246 c0", wb_cyc4, wb_we4, wb_adr4, wb_sel4);
        end
        @(negedge clk);
        n_cmp++;
        if ({done4, rdata4} !== {1'b1, 16'hBEEF}) begin
            n_fail++; $display("FAIL lw4_ld_data: got done%b rd%h expected done1 beef", done4, rdata4);
        end
        @(negedge clk);
        op = OP_ST; byte_mode = 1'b1; addr_in = 16'h2005; wdata_in = 16'h00A5; req_valid4 = 1'b1;
        @(negedge clk);
        req_valid4 = 1'b0;
        n_cmp++;
        if ({wb_we4, wb_adr4, wb_sel4, wb_dat_m4} !== {1'b1, 13'h0400, 8'h20, 64'h0000_A5A5_0000_0000}) begin
            n_fail++; $display("FAIL lw4_st_bus: got we%b adr%h sel%h dat%h expected 1 0400 20 0000a5a500000000",
                               wb_we4, wb_adr4, wb_sel4, wb_dat_m4);
        end
        @(negedge clk);
        n_cmp++;
        if (done4 !== 1'b1) begin n_fail++; $display("FAIL lw4_st_done: got %b expected 1", done4); end
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            mem[i] = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        test_reset();
        test_idle_none();
        test_directed();
        test_reset_mid();
        test_random();
        test_lw4();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
